pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline with BTB.
- Drives PC and IF/ID write enables, and flushes IF/ID, ID/EX and EX/MEM.
- Detects load-use hazards, holds the pipe while data memory is busy, and recovers from BTB mispredictions resolved in MEM.
- On recovery it redirects the PC and issues one BTB update; it also keeps saturating stall/flush performance counters.

Parameters:
- CNT_W, 16, width of performance counters.
- MEM_TIMEOUT, 255, max consecutive MemBusy cycles before Timeout flags.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- ID_EX_MemRead  in  1  EX-stage instruction is a load.
- ID_EX_Rt  in  5  load destination register.
- IF_ID_Rs  in  5  ID-stage source register Rs.
- IF_ID_Rt  in  5  ID-stage source register Rt.
- EX_MEM_Branch  in  1  MEM-stage instruction is a branch.
- EX_MEM_Predicted  in  1  BTB predicted taken for that branch.
- BranchTaken  in  1  resolved branch outcome in MEM.
- EX_MEM_Update  in  32  correct next PC for the MEM-stage branch.
- EX_MEM_PC  in  32  PC of the MEM-stage branch.
- MemBusy  in  1  data memory not ready this cycle.
- PCWrite  out  1  PC register enable.
- IF_ID_Write  out  1  IF/ID register enable.
- IF_ID_Flush  out  1  zero IF/ID at next edge.
- ID_EX_Flush  out  1  zero ID/EX control bits at next edge.
- EX_MEM_Flush  out  1  zero EX/MEM control bits at next edge.
- Hold  out  1  hold ID/EX and EX/MEM (memory wait).
- Redirect  out  1  PC mux selects RedirectPC.
- RedirectPC  out  32  recovery PC.
- BTB_Write  out  1  one-cycle BTB update strobe.
- BTB_PC  out  32  BTB index PC.
- BTB_Target  out  32  BTB target.
- BTB_Taken  out  1  BTB outcome.
- Timeout  out  1  sticky memory-wait timeout.
- StallCount  out  CNT_W  saturating count of stall cycles.
- FlushCount  out  CNT_W  saturating count of mispredict recoveries.

Behaviour:
- States: RUN, MEM_WAIT, BTB_UPD.
- Reset (Rst=1 at edge, from any state):
  - state=RUN; StallCount=0, FlushCount=0, Timeout=0, wait counter=0.
  - BTB_PC/BTB_Target/BTB_Taken regs=0.
  - While Rst is high, all outputs take RUN-idle values: PCWrite=1, IF_ID_Write=1, all flushes=0, Hold=0, Redirect=0, BTB_Write=0.
- Mispredict, combinational: Mispredict = EX_MEM_Branch & (BranchTaken != EX_MEM_Predicted).
- Load-use, combinational: LoadUse = ID_EX_MemRead & ID_EX_Rt!=0 & (ID_EX_Rt==IF_ID_Rs | ID_EX_Rt==IF_ID_Rt).
- Priority, evaluated in RUN or BTB_UPD each cycle: MemBusy > Mispredict > LoadUse.
- MemBusy=1:
  - Outputs: PCWrite=0, IF_ID_Write=0, Hold=1, no flushes, Redirect=0.
  - Next state MEM_WAIT; wait counter=1; StallCount+1.
- MEM_WAIT:
  - Same hold outputs while MemBusy=1.
  - Wait counter increments each cycle, saturating at MEM_TIMEOUT; when it reaches MEM_TIMEOUT, Timeout sets and stays set until Rst.
  - StallCount +1 per held cycle.
  - When MemBusy=0, that cycle behaves as RUN (priority rules apply) and the next state follows them.
- Mispredict, MemBusy=0:
  - Same cycle outputs: Redirect=1, RedirectPC=EX_MEM_Update, IF_ID_Flush=ID_EX_Flush=EX_MEM_Flush=1, PCWrite=1.
  - Registers BTB_PC=EX_MEM_PC, BTB_Target=EX_MEM_Update, BTB_Taken=BranchTaken.
  - FlushCount+1; next state BTB_UPD.
  - Any concurrent LoadUse is ignored, since the younger instructions are flushed.
- BTB_UPD: BTB_Write=1 for exactly one cycle with the registered values; pipe runs normally under the priority rules; next state RUN, or MEM_WAIT if MemBusy.
  - A fresh mispredict in BTB_UPD is impossible, because the pipe was just flushed.
  - If one occurs anyway, it is handled normally: the new BTB regs are captured and the state stays BTB_UPD.
- LoadUse only: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 (one bubble); StallCount+1; state unchanged.
- Latency: recovery PC is applied at the first edge after detection; the BTB write lands one cycle later.
- Counters saturate at all-ones and never wrap.
- RedirectPC=EX_MEM_Update combinationally whenever Redirect=1, else 0.

Decomposition:
- Shared package holds:
  - State encoding localparams: RUN=2'd0, MEM_WAIT=2'd1, BTB_UPD=2'd2.
  - Register-zero constant.
- One sub-module, sat_counter (parameter W; inc, clear), instantiated twice for StallCount/FlushCount.
- Hazard and FSM logic stay in the top module.

Test Plan:
- Reset mid-MEM_WAIT (MemBusy=1 for 3 cycles, then Rst) -> next cycle state RUN, StallCount=0, Timeout=0, PCWrite=1.
- Load-use: ID_EX_MemRead=1, ID_EX_Rt=5, IF_ID_Rs=5 for 1 cycle -> PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, StallCount=1.
  - Same stimulus with Rt=0 -> no stall.
- Mispredict: EX_MEM_Branch=1, Predicted=0, BranchTaken=1, Update=32'h0040_0020, PC=32'h0040_0008 ->
  - Same cycle: Redirect=1, RedirectPC=0x00400020, three flushes=1.
  - Next cycle: BTB_Write=1, BTB_PC=0x00400008, BTB_Target=0x00400020, BTB_Taken=1; FlushCount=1.
- MemBusy and mispredict simultaneous for 2 cycles, then MemBusy drops -> Hold=1 and no Redirect for 2 cycles; Redirect on the 3rd cycle.
- MEM_TIMEOUT=4, MemBusy held 6 cycles -> Timeout=1 after the 4th held cycle; it stays 1 after MemBusy drops.
- Counter saturation: CNT_W=4, 20 load-use cycles -> StallCount=15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer.
// Holds the FSM state encoding, the register-zero constant and a small
// register-compare helper used by the load-use detector.
package pipe_hazard_ctrl_pkg;

   // FSM state encoding (2-bit; encoding 2'd3 is unused and treated as RUN)
   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] MEM_WAIT = 2'd1;
   localparam logic [1:0] BTB_UPD  = 2'd2;

   // $zero never carries a true dependency
   localparam logic [4:0] REG_ZERO = 5'd0;

   // True when a producer register feeds a consumer register (never for $zero)
   function automatic logic reg_dep(input logic [4:0] prod, input logic [4:0] cons);
      return (prod != REG_ZERO) && (prod == cons);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
// Ports: i_Clk clock, i_clear synchronous clear (dominates), i_inc count
// enable, o_count current value; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         i_Clk,
   input  logic         i_clear,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_Clk) begin
      if (i_clear) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline with a BTB.
// Inputs: hazard sources (load in EX, ID sources, MEM-stage branch
// resolution, data-memory busy). Outputs: PC/IF_ID enables, three stage
// flushes, memory-wait hold, PC redirect, one-shot BTB update, sticky
// memory timeout and saturating stall/flush counters.
// Priority each cycle: MemBusy > mispredict > load-use.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic              i_Clk,
   input  logic              i_Rst,
   input  logic              i_ID_EX_MemRead,
   input  logic [4:0]        i_ID_EX_Rt,
   input  logic [4:0]        i_IF_ID_Rs,
   input  logic [4:0]        i_IF_ID_Rt,
   input  logic              i_EX_MEM_Branch,
   input  logic              i_EX_MEM_Predicted,
   input  logic              i_BranchTaken,
   input  logic [31:0]       i_EX_MEM_Update,
   input  logic [31:0]       i_EX_MEM_PC,
   input  logic              i_MemBusy,
   output logic              o_PCWrite,
   output logic              o_IF_ID_Write,
   output logic              o_IF_ID_Flush,
   output logic              o_ID_EX_Flush,
   output logic              o_EX_MEM_Flush,
   output logic              o_Hold,
   output logic              o_Redirect,
   output logic [31:0]       o_RedirectPC,
   output logic              o_BTB_Write,
   output logic [31:0]       o_BTB_PC,
   output logic [31:0]       o_BTB_Target,
   output logic              o_BTB_Taken,
   output logic              o_Timeout,
   output logic [CNT_W-1:0]  o_StallCount,
   output logic [CNT_W-1:0]  o_FlushCount
);

   localparam int               WAIT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [WAIT_W-1:0] r_wait;
   logic [WAIT_W-1:0] w_wait_nxt;
   logic              r_timeout;
   logic [31:0]       r_btb_pc;
   logic [31:0]       r_btb_target;
   logic              r_btb_taken;

   logic w_mispredict;
   logic w_load_use;
   logic w_recover;
   logic w_lu_stall;
   logic w_stall_inc;
   logic w_flush_inc;

   // ---------------------------------------------------------------------
   // Hazard detection and priority resolution
   // ---------------------------------------------------------------------
   assign w_mispredict = i_EX_MEM_Branch & (i_BranchTaken != i_EX_MEM_Predicted);
   assign w_load_use   = i_ID_EX_MemRead &
                         (reg_dep(i_ID_EX_Rt, i_IF_ID_Rs) | reg_dep(i_ID_EX_Rt, i_IF_ID_Rt));

   // A memory wait freezes everything, so a pending mispredict is deferred
   // until MemBusy drops. A recovery flushes the younger instructions, which
   // makes any concurrent load-use moot.
   assign w_recover  = ~i_MemBusy & w_mispredict;
   assign w_lu_stall = ~i_MemBusy & ~w_mispredict & w_load_use;

   assign w_stall_inc = ~i_Rst & (i_MemBusy | w_lu_stall);
   assign w_flush_inc = ~i_Rst & w_recover;

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // MEM_WAIT with MemBusy low behaves as RUN, and BTB_UPD lasts one cycle,
   // so every state follows the same priority rules. A load-use stall from
   // BTB_UPD returns to RUN so the BTB strobe is never repeated.
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = RUN;
      case (r_state)
         RUN, MEM_WAIT, BTB_UPD: begin
            if (i_MemBusy) begin
               w_state_nxt = MEM_WAIT;
            end else if (w_mispredict) begin
               w_state_nxt = BTB_UPD;
            end else begin
               w_state_nxt = RUN;
            end
         end
         default: w_state_nxt = RUN;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: output logic (RUN-idle values while in reset)
   // ---------------------------------------------------------------------
   always_comb begin
      o_PCWrite      = 1'b1;
      o_IF_ID_Write  = 1'b1;
      o_IF_ID_Flush  = 1'b0;
      o_ID_EX_Flush  = 1'b0;
      o_EX_MEM_Flush = 1'b0;
      o_Hold         = 1'b0;
      o_Redirect     = 1'b0;
      o_BTB_Write    = 1'b0;
      if (!i_Rst) begin
         o_BTB_Write = (r_state == BTB_UPD);
         if (i_MemBusy) begin
            o_PCWrite     = 1'b0;
            o_IF_ID_Write = 1'b0;
            o_Hold        = 1'b1;
         end else if (w_mispredict) begin
            o_Redirect     = 1'b1;
            o_IF_ID_Flush  = 1'b1;
            o_ID_EX_Flush  = 1'b1;
            o_EX_MEM_Flush = 1'b1;
         end else if (w_load_use) begin
            // Freeze PC and IF/ID, inject one bubble into ID/EX
            o_PCWrite     = 1'b0;
            o_IF_ID_Write = 1'b0;
            o_ID_EX_Flush = 1'b1;
         end
      end
   end

   assign o_RedirectPC = o_Redirect ? i_EX_MEM_Update : 32'd0;

   // ---------------------------------------------------------------------
   // Memory-wait counter and sticky timeout
   // The counter tracks consecutive busy cycles: 1 on the first one,
   // saturating at MEM_TIMEOUT, and cleared as soon as MemBusy drops.
   // ---------------------------------------------------------------------
   always_comb begin
      w_wait_nxt = '0;
      if (i_MemBusy) begin
         if (r_state != MEM_WAIT) begin
            w_wait_nxt = WAIT_W'(1);
         end else if (r_wait == WAIT_MAX) begin
            w_wait_nxt = r_wait;
         end else begin
            w_wait_nxt = r_wait + WAIT_W'(1);
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_wait    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_wait <= w_wait_nxt;
         if (i_MemBusy && (w_wait_nxt == WAIT_MAX)) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign o_Timeout = r_timeout;

   // ---------------------------------------------------------------------
   // BTB update capture; written out during the following BTB_UPD cycle
   // ---------------------------------------------------------------------
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_btb_pc     <= 32'd0;
         r_btb_target <= 32'd0;
         r_btb_taken  <= 1'b0;
      end else if (w_recover) begin
         r_btb_pc     <= i_EX_MEM_PC;
         r_btb_target <= i_EX_MEM_Update;
         r_btb_taken  <= i_BranchTaken;
      end
   end

   assign o_BTB_PC     = r_btb_pc;
   assign o_BTB_Target = r_btb_target;
   assign o_BTB_Taken  = r_btb_taken;

   // ---------------------------------------------------------------------
   // Performance counters
   // ---------------------------------------------------------------------
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .i_Clk   (i_Clk),
      .i_clear (i_Rst),
      .i_inc   (w_stall_inc),
      .o_count (o_StallCount)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .i_Clk   (i_Clk),
      .i_clear (i_Rst),
      .i_inc   (w_flush_inc),
      .o_count (o_FlushCount)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

   localparam int CNT_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              id_ex_memread;
   logic [4:0]        id_ex_rt;
   logic [4:0]        if_id_rs;
   logic [4:0]        if_id_rt;
   logic              ex_mem_branch;
   logic              ex_mem_predicted;
   logic              branch_taken;
   logic [31:0]       ex_mem_update;
   logic [31:0]       ex_mem_pc;
   logic              mem_busy;
   logic              pc_write;
   logic              if_id_write;
   logic              if_id_flush;
   logic              id_ex_flush;
   logic              ex_mem_flush;
   logic              hold;
   logic              redirect;
   logic [31:0]       redirect_pc;
   logic              btb_write;
   logic [31:0]       btb_pc;
   logic [31:0]       btb_target;
   logic              btb_taken;
   logic              timeout;
   logic [CNT_W-1:0]  stall_count;
   logic [CNT_W-1:0]  flush_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
      .i_Clk              (clk),
      .i_Rst              (rst),
      .i_ID_EX_MemRead    (id_ex_memread),
      .i_ID_EX_Rt         (id_ex_rt),
      .i_IF_ID_Rs         (if_id_rs),
      .i_IF_ID_Rt         (if_id_rt),
      .i_EX_MEM_Branch    (ex_mem_branch),
      .i_EX_MEM_Predicted (ex_mem_predicted),
      .i_BranchTaken      (branch_taken),
      .i_EX_MEM_Update    (ex_mem_update),
      .i_EX_MEM_PC        (ex_mem_pc),
      .i_MemBusy          (mem_busy),
      .o_PCWrite          (pc_write),
      .o_IF_ID_Write      (if_id_write),
      .o_IF_ID_Flush      (if_id_flush),
      .o_ID_EX_Flush      (id_ex_flush),
      .o_EX_MEM_Flush     (ex_mem_flush),
      .o_Hold             (hold),
      .o_Redirect         (redirect),
      .o_RedirectPC       (redirect_pc),
      .o_BTB_Write        (btb_write),
      .o_BTB_PC           (btb_pc),
      .o_BTB_Target       (btb_target),
      .o_BTB_Taken        (btb_taken),
      .o_Timeout          (timeout),
      .o_StallCount       (stall_count),
      .o_FlushCount       (flush_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after an input change
   task automatic settle();
      #2;
   endtask

   task automatic idle_inputs();
      id_ex_memread    = 1'b0;
      id_ex_rt         = 5'd0;
      if_id_rs         = 5'd0;
      if_id_rt         = 5'd0;
      ex_mem_branch    = 1'b0;
      ex_mem_predicted = 1'b0;
      branch_taken     = 1'b0;
      ex_mem_update    = 32'd0;
      ex_mem_pc        = 32'd0;
      mem_busy         = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();

      // ---------------- reset state ----------------
      settle();
      check("rst_pcwrite",  {31'd0, pc_write}, 32'd1);
      check("rst_stall",    {28'd0, stall_count}, 32'd0);
      check("rst_btb_pc",   btb_pc, 32'd0);
      rst = 1'b0;
      tick();

      // ---------------- MemBusy 3 cycles, then reset mid-MEM_WAIT ----------------
      mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("mw_hold",    {31'd0, hold}, 32'd1);
         check("mw_pcwrite", {31'd0, pc_write}, 32'd0);
         tick();
      end
      check("mw_stall3", {28'd0, stall_count}, 32'd3);
      rst = 1'b1;
      settle();
      check("rst_idle_pcwrite", {31'd0, pc_write}, 32'd1);
      check("rst_idle_hold",    {31'd0, hold}, 32'd0);
      tick();
      rst = 1'b0;
      mem_busy = 1'b0;
      settle();
      check("post_rst_stall",   {28'd0, stall_count}, 32'd0);
      check("post_rst_timeout", {31'd0, timeout}, 32'd0);
      check("post_rst_pcwrite", {31'd0, pc_write}, 32'd1);
      check("post_rst_btbw",    {31'd0, btb_write}, 32'd0);
      tick();

      // ---------------- load-use on Rs ----------------
      id_ex_memread = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5; if_id_rt = 5'd9;
      settle();
      check("lu_pcwrite", {31'd0, pc_write}, 32'd0);
      check("lu_ifidw",   {31'd0, if_id_write}, 32'd0);
      check("lu_idexfl",  {31'd0, id_ex_flush}, 32'd1);
      check("lu_ifidfl",  {31'd0, if_id_flush}, 32'd0);
      tick();
      check("lu_stall1", {28'd0, stall_count}, 32'd1);

      // Rt = $zero never stalls
      id_ex_rt = 5'd0; if_id_rs = 5'd0;
      settle();
      check("lu0_pcwrite", {31'd0, pc_write}, 32'd1);
      check("lu0_idexfl",  {31'd0, id_ex_flush}, 32'd0);
      tick();
      check("lu0_stall", {28'd0, stall_count}, 32'd1);

      // load-use on IF_ID_Rt
      id_ex_rt = 5'd7; if_id_rs = 5'd3; if_id_rt = 5'd7;
      settle();
      check("lurt_pcwrite", {31'd0, pc_write}, 32'd0);
      tick();
      check("lurt_stall", {28'd0, stall_count}, 32'd2);

      // matching registers but not a load
      id_ex_memread = 1'b0;
      settle();
      check("nold_pcwrite", {31'd0, pc_write}, 32'd1);
      tick();
      idle_inputs();

      // ---------------- correctly predicted branch ----------------
      ex_mem_branch = 1'b1; ex_mem_predicted = 1'b1; branch_taken = 1'b1;
      ex_mem_update = 32'h0040_0040;
      settle();
      check("okbr_redirect", {31'd0, redirect}, 32'd0);
      check("okbr_rpc",      redirect_pc, 32'd0);
      tick();

      // ---------------- mispredict (with concurrent load-use) ----------------
      ex_mem_branch = 1'b1; ex_mem_predicted = 1'b0; branch_taken = 1'b1;
      ex_mem_update = 32'h0040_0020; ex_mem_pc = 32'h0040_0008;
      id_ex_memread = 1'b1; id_ex_rt = 5'd4; if_id_rs = 5'd4;
      settle();
      check("mp_redirect", {31'd0, redirect}, 32'd1);
      check("mp_rpc",      redirect_pc, 32'h0040_0020);
      check("mp_flushes",  {29'd0, if_id_flush, id_ex_flush, ex_mem_flush}, 32'h7);
      check("mp_pcwrite",  {31'd0, pc_write}, 32'd1);
      check("mp_ifidw",    {31'd0, if_id_write}, 32'd1);
      check("mp_btbw0",    {31'd0, btb_write}, 32'd0);
      tick();
      idle_inputs();
      settle();
      check("mp_btbw1",    {31'd0, btb_write}, 32'd1);
      check("mp_btb_pc",   btb_pc, 32'h0040_0008);
      check("mp_btb_tgt",  btb_target, 32'h0040_0020);
      check("mp_btb_tkn",  {31'd0, btb_taken}, 32'd1);
      check("mp_flushcnt", {28'd0, flush_count}, 32'd1);
      check("mp_stall",    {28'd0, stall_count}, 32'd2);
      check("mp_rpc_idle", redirect_pc, 32'd0);
      tick();
      settle();
      check("mp_btbw_once", {31'd0, btb_write}, 32'd0);
      tick();

      // ---------------- MemBusy + mispredict for 2 cycles ----------------
      ex_mem_branch = 1'b1; ex_mem_predicted = 1'b1; branch_taken = 1'b0;
      ex_mem_update = 32'h0040_0100; ex_mem_pc = 32'h0040_0010;
      mem_busy = 1'b1;
      for (int i = 0; i < 2; i++) begin
         settle();
         check("mbmp_hold",     {31'd0, hold}, 32'd1);
         check("mbmp_redirect", {31'd0, redirect}, 32'd0);
         check("mbmp_flush",    {31'd0, ex_mem_flush}, 32'd0);
         tick();
      end
      mem_busy = 1'b0;
      settle();
      check("mbmp_redirect3", {31'd0, redirect}, 32'd1);
      check("mbmp_rpc3",      redirect_pc, 32'h0040_0100);
      check("mbmp_hold3",     {31'd0, hold}, 32'd0);
      tick();
      idle_inputs();
      settle();
      check("mbmp_btbw",     {31'd0, btb_write}, 32'd1);
      check("mbmp_btb_pc",   btb_pc, 32'h0040_0010);
      check("mbmp_btb_tkn",  {31'd0, btb_taken}, 32'd0);
      check("mbmp_flushcnt", {28'd0, flush_count}, 32'd2);
      check("mbmp_stall",    {28'd0, stall_count}, 32'd4);
      tick();

      // ---------------- timeout: MemBusy for 6 cycles (MEM_TIMEOUT=4) ----------------
      mem_busy = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check($sformatf("to_cyc%0d", i), {31'd0, timeout}, (i >= 4) ? 32'd1 : 32'd0);
      end
      mem_busy = 1'b0;
      tick();
      check("to_sticky", {31'd0, timeout}, 32'd1);
      check("to_stall",  {28'd0, stall_count}, 32'd10);

      // ---------------- stall counter saturation ----------------
      id_ex_memread = 1'b1; id_ex_rt = 5'd12; if_id_rs = 5'd12;
      for (int i = 0; i < 20; i++) tick();
      check("sat_stall", {28'd0, stall_count}, 32'd15);
      idle_inputs();

      // reset clears the sticky timeout and counters
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      check("end_timeout", {31'd0, timeout}, 32'd0);
      check("end_flush",   {28'd0, flush_count}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
